fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL import rv32i_pkg::* and use DPW (32) for all address/data widths.
REQ-002 Parameter ResetPC, default 0, PC value loaded on reset.
REQ-003 Parameter ImemBytes, default 120, instruction memory size in bytes; last legal fetch PC = ImemBytes-4.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 StallF  input  1  hold PCF.
REQ-007 StallD  input  1  hold IF/ID register.
REQ-008 FlushD  input  1  replace IF/ID contents with bubble.
REQ-009 PCSrcE  input  1  redirect request from execute stage.
REQ-010 PCTargetE  input  DPW  redirect target address.
REQ-011 instr  input  DPW  word returned by i_cache for current PCF (combinational, same cycle).
REQ-012 PCF  output  DPW  fetch address driven to i_cache.
REQ-013 InstrD  output  DPW  registered instruction to decode.
REQ-014 PCD  output  DPW  registered PC of InstrD.
REQ-015 PCPlus4D  output  DPW  registered PCD+4.
REQ-016 ValidD  output  1  InstrD is a real fetched instruction.
REQ-017 FetchFault  output  1  sticky: illegal next PC detected.
REQ-018 FetchCnt  output  16  count of valid instructions loaded into IF/ID.

Function
REQ-019 FSM states BOOT, RUN, HALT; BOOT entered on reset.
REQ-020 BOOT: lasts exactly one cycle, PCF held, IF/ID not loaded (bubble), unconditional transition to RUN.
REQ-021 RUN next-PC: PCSrcE ? PCTargetE : PCF+4, 32-bit modulo add.
REQ-022 RUN PCF update: PCSrcE=1 updates PCF regardless of StallF; else StallF=0 updates to PCF+4; StallF=1 with PCSrcE=0 holds.
REQ-023 Illegal next PC: bits[1:0]!=0 or value > ImemBytes-4; checked only when PCF would update.
REQ-024 Illegal next PC: PCF not updated, FSM -> HALT, FetchFault set next edge.
REQ-025 HALT: PCF frozen, FetchFault=1, IF/ID loads bubble every cycle, all inputs ignored; exit only by reset.
REQ-026 Bubble: InstrD=32'h00000013 (NOP), PCD=0, PCPlus4D=0, ValidD=0.
REQ-027 IF/ID priority per edge: HALT or BOOT or FlushD or PCSrcE -> bubble; else StallD=1 -> hold; else load instr, PCF, PCF+4, ValidD=1.
REQ-028 FlushD beats StallD when both asserted.
REQ-029 FetchCnt increments by 1 on each edge that loads ValidD=1 from instr; wraps 16'hFFFF->0; holds on stall/bubble.
REQ-030 Latency: instr sampled at PCF in cycle N appears on InstrD in cycle N+1.
REQ-031 No combinational path from any input to PCF, InstrD, PCD, PCPlus4D, ValidD, FetchFault, FetchCnt.

Reset
REQ-032 rst_n=0 asynchronously forces: state=BOOT, PCF=ResetPC, IF/ID=bubble, FetchFault=0, FetchCnt=0.
REQ-033 Reset asserted mid-operation (any state, including HALT) takes effect immediately without waiting for clk.
REQ-034 After rst_n rises, first edge is BOOT cycle; first valid InstrD appears on third edge.

Verification
REQ-035 Reset, then instr=0x00500113 at PCF=0, 0x00C00193 at PCF=4 -> edge3: InstrD=0x00500113, PCD=0, PCPlus4D=4, ValidD=1; edge4: InstrD=0x00C00193, PCD=4, FetchCnt=2.
REQ-036 StallF=StallD=1 for 3 cycles at PCF=8 -> PCF stays 8, InstrD/PCD/FetchCnt unchanged, then resume at 12.
REQ-037 PCSrcE=1, PCTargetE=0x40 with StallF=1, StallD=1 -> next edge PCF=0x40, ValidD=0, InstrD=0x00000013.
REQ-038 FlushD=1 and StallD=1 same cycle -> bubble loaded, FetchCnt unchanged.
REQ-039 Sequential run to PCF=116 (ImemBytes=120) -> PCF holds 116, HALT, FetchFault=1, ValidD=0 thereafter; PCSrcE=1 target 0 ignored.
REQ-040 PCSrcE=1, PCTargetE=0x42 -> HALT, FetchFault=1, PCF unchanged; async rst_n pulse mid-clock -> PCF=0, FetchFault=0 immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC register, BOOT/RUN/HALT control FSM and the IF/ID pipeline register.
// The shared width package sits first in this file so the fetch stage stays self-contained.
package rv32i_pkg;
   localparam int DPW = 32;
endpackage

module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [DPW-1:0] ResetPC   = '0,
   parameter int             ImemBytes = 120
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           StallF,
   input  logic           StallD,
   input  logic           FlushD,
   input  logic           PCSrcE,
   input  logic [DPW-1:0] PCTargetE,
   input  logic [DPW-1:0] instr,
   output logic [DPW-1:0] PCF,
   output logic [DPW-1:0] InstrD,
   output logic [DPW-1:0] PCD,
   output logic [DPW-1:0] PCPlus4D,
   output logic           ValidD,
   output logic           FetchFault,
   output logic [15:0]    FetchCnt
);

   localparam logic [DPW-1:0] LastPc  = DPW'(ImemBytes - 4);
   localparam logic [DPW-1:0] NopInstr = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } state_t;

   state_t         state;
   logic [DPW-1:0] pc_plus4;
   logic [DPW-1:0] next_pc;
   logic           pc_update;
   logic           next_illegal;
   logic           bubble_d;
   logic           load_d;

   // A redirect always moves the PC, even through a fetch stall; an illegal target freezes it instead.
   always_comb begin
      pc_plus4     = PCF + 32'd4;
      next_pc      = PCSrcE ? PCTargetE : pc_plus4;
      pc_update    = (state == RUN) && (PCSrcE || !StallF);
      next_illegal = (next_pc[1:0] != 2'b00) || (next_pc > LastPc);
      bubble_d     = (state != RUN) || FlushD || PCSrcE;
      load_d       = !bubble_d && !StallD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         PCF        <= ResetPC;
         FetchFault <= 1'b0;
      end else begin
         case (state)
            BOOT: state <= RUN;
            RUN: begin
               if (pc_update) begin
                  if (next_illegal) begin
                     state      <= HALT;
                     FetchFault <= 1'b1;
                  end else begin
                     PCF <= next_pc;
                  end
               end
            end
            HALT: FetchFault <= 1'b1;
            default: state <= BOOT;
         endcase
      end
   end

   // Bubble outranks hold, so a flush wins over a decode stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         InstrD   <= NopInstr;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
         FetchCnt <= '0;
      end else if (bubble_d) begin
         InstrD   <= NopInstr;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (load_d) begin
         InstrD   <= instr;
         PCD      <= PCF;
         PCPlus4D <= pc_plus4;
         ValidD   <= 1'b1;
         FetchCnt <= FetchCnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;
   import rv32i_pkg::*;

   localparam int          LAST_PC = 116;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam int          M_BOOT  = 0;
   localparam int          M_RUN   = 1;
   localparam int          M_HALT  = 2;

   logic        clk, rst_n, StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE, instr, PCF, InstrD, PCD, PCPlus4D;
   logic        ValidD, FetchFault;
   logic [15:0] FetchCnt;

   logic [31:0] imem [0:29];

   int          m_mode;
   logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
   logic        m_valid, m_fault;
   logic [15:0] m_cnt;
   int          passed, total;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .instr(instr), .PCF(PCF), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchFault(FetchFault), .FetchCnt(FetchCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory answers combinationally for whatever address the DUT presents.
   always_comb begin
      instr = 32'hDEAD_BEEF;
      if (PCF < 32'd120) instr = imem[PCF[6:2]];
   end

   task automatic clear_inputs();
      StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
   endtask

   task automatic model_reset();
      m_mode = M_BOOT; m_pc = 0; m_instr = NOP; m_pcd = 0; m_pcp4 = 0;
      m_valid = 0; m_fault = 0; m_cnt = 0;
   endtask

   task automatic model_bubble();
      m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
   endtask

   // Advance the reference model by one clock using the current inputs, then wait for the edge.
   task automatic tick();
      logic [31:0] nxt;
      bit upd, bad;
      if (m_mode == M_BOOT) begin
         model_bubble();
         m_mode = M_RUN;
      end else if (m_mode == M_HALT) begin
         model_bubble();
      end else begin
         upd = PCSrcE || !StallF;
         nxt = PCSrcE ? PCTargetE : m_pc + 32'd4;
         bad = upd && ((nxt % 4) != 0 || nxt > LAST_PC);
         if (FlushD || PCSrcE) model_bubble();
         else if (!StallD) begin
            m_instr = imem[m_pc / 4]; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4;
            m_valid = 1; m_cnt = m_cnt + 16'd1;
         end
         if (bad) begin m_mode = M_HALT; m_fault = 1; end
         else if (upd) m_pc = nxt;
      end
      @(posedge clk);
      #1;
   endtask

   // The edge seen while rst_n is still low is the first counted edge; release just after it.
   task automatic do_release();
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; clear_inputs(); model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (PCF !== 32'h0) $display("[TB] FAIL reset_pcf: got %h want 0", PCF); else passed++;
      total++; if (InstrD !== NOP) $display("[TB] FAIL reset_instrd: got %h want %h", InstrD, NOP); else passed++;
      total++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) $display("[TB] FAIL reset_pcd: got %h/%h want 0/0", PCD, PCPlus4D); else passed++;
      total++; if (ValidD !== 1'b0) $display("[TB] FAIL reset_validd: got %b want 0", ValidD); else passed++;
      total++; if (FetchFault !== 1'b0) $display("[TB] FAIL reset_fault: got %b want 0", FetchFault); else passed++;
      total++; if (FetchCnt !== 16'h0) $display("[TB] FAIL reset_cnt: got %0d want 0", FetchCnt); else passed++;
   endtask

   task automatic test_sequential();
      do_release();
      tick();
      total++; if (ValidD !== 1'b0 || PCF !== 32'h0) $display("[TB] FAIL boot_bubble: got valid=%b pcf=%h want 0/0", ValidD, PCF); else passed++;
      tick();
      total++; if (InstrD !== 32'h0050_0113 || PCD !== 32'h0 || PCPlus4D !== 32'h4 || ValidD !== 1'b1)
         $display("[TB] FAIL first_fetch: got %h pcd=%h p4=%h v=%b want 00500113 0 4 1", InstrD, PCD, PCPlus4D, ValidD);
      else passed++;
      tick();
      total++; if (InstrD !== 32'h00C0_0193 || PCD !== 32'h4 || FetchCnt !== 16'd2 || PCF !== 32'h8)
         $display("[TB] FAIL second_fetch: got %h pcd=%h cnt=%0d pcf=%h want 00c00193 4 2 8", InstrD, PCD, FetchCnt, PCF);
      else passed++;
   endtask

   task automatic test_stall();
      StallF = 1; StallD = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (PCF !== 32'h8 || InstrD !== 32'h00C0_0193 || PCD !== 32'h4 || FetchCnt !== 16'd2)
            $display("[TB] FAIL stall_hold%0d: got pcf=%h instr=%h pcd=%h cnt=%0d want 8 00c00193 4 2", i, PCF, InstrD, PCD, FetchCnt);
         else passed++;
      end
      StallF = 0; StallD = 0;
      tick();
      total++; if (PCF !== 32'hC || InstrD !== imem[2] || PCD !== 32'h8 || FetchCnt !== 16'd3)
         $display("[TB] FAIL stall_resume: got pcf=%h instr=%h pcd=%h cnt=%0d want c %h 8 3", PCF, InstrD, PCD, FetchCnt, imem[2]);
      else passed++;
   endtask

   task automatic test_redirect_under_stall();
      StallF = 1; StallD = 1; PCSrcE = 1; PCTargetE = 32'h40;
      tick();
      total++; if (PCF !== 32'h40 || ValidD !== 1'b0 || InstrD !== NOP || FetchCnt !== 16'd3)
         $display("[TB] FAIL redirect_stall: got pcf=%h v=%b instr=%h cnt=%0d want 40 0 %h 3", PCF, ValidD, InstrD, FetchCnt, NOP);
      else passed++;
      clear_inputs();
   endtask

   task automatic test_flush_beats_stall();
      FlushD = 1; StallD = 1;
      tick();
      total++; if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || FetchCnt !== 16'd3 || PCF !== 32'h44)
         $display("[TB] FAIL flush_stall: got v=%b instr=%h pcd=%h cnt=%0d pcf=%h want 0 %h 0 3 44", ValidD, InstrD, PCD, FetchCnt, PCF, NOP);
      else passed++;
      clear_inputs();
      tick();
      total++; if (InstrD !== imem[17] || PCD !== 32'h44 || FetchCnt !== 16'd4)
         $display("[TB] FAIL after_flush: got instr=%h pcd=%h cnt=%0d want %h 44 4", InstrD, PCD, FetchCnt, imem[17]);
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         StallF    = ($urandom_range(0, 3) == 0);
         StallD    = ($urandom_range(0, 3) == 0);
         FlushD    = ($urandom_range(0, 7) == 0);
         PCSrcE    = ($urandom_range(0, 7) == 0) || (m_pc >= 32'd100);
         PCTargetE = 32'($urandom_range(0, 29) * 4);
         tick();
         total++;
         if (PCF !== m_pc || InstrD !== m_instr || PCD !== m_pcd || PCPlus4D !== m_pcp4 ||
             ValidD !== m_valid || FetchFault !== m_fault || FetchCnt !== m_cnt)
            $display("[TB] FAIL random_cycle%0d: got pcf=%h instr=%h pcd=%h p4=%h v=%b f=%b cnt=%0d want %h %h %h %h %b %b %0d",
                     i, PCF, InstrD, PCD, PCPlus4D, ValidD, FetchFault, FetchCnt,
                     m_pc, m_instr, m_pcd, m_pcp4, m_valid, m_fault, m_cnt);
         else passed++;
      end
      clear_inputs();
   endtask

   task automatic test_halt_at_end();
      PCSrcE = 1; PCTargetE = 32'd100;
      tick();
      clear_inputs();
      for (int i = 0; i < 20 && m_mode != M_HALT; i++) tick();
      total++; if (PCF !== 32'd116 || FetchFault !== 1'b1 || InstrD !== imem[29] || PCD !== 32'd116 || ValidD !== 1'b1)
         $display("[TB] FAIL end_halt: got pcf=%h f=%b instr=%h pcd=%h v=%b want 74 1 %h 74 1", PCF, FetchFault, InstrD, PCD, ValidD, imem[29]);
      else passed++;
      PCSrcE = 1; PCTargetE = 32'h0;
      for (int i = 0; i < 3; i++) begin
         StallD = $urandom_range(0, 1) == 1;
         tick();
         total++; if (PCF !== 32'd116 || ValidD !== 1'b0 || FetchFault !== 1'b1 || InstrD !== NOP || FetchCnt !== m_cnt)
            $display("[TB] FAIL halt_ignore%0d: got pcf=%h v=%b f=%b instr=%h cnt=%0d want 74 0 1 %h %0d", i, PCF, ValidD, FetchFault, InstrD, FetchCnt, NOP, m_cnt);
         else passed++;
      end
      clear_inputs();
   endtask

   task automatic test_misaligned_and_async_reset();
      rst_n = 0;
      #1;
      total++; if (PCF !== 32'h0 || FetchFault !== 1'b0 || InstrD !== NOP || FetchCnt !== 16'h0)
         $display("[TB] FAIL async_reset_halt: got pcf=%h f=%b instr=%h cnt=%0d want 0 0 %h 0", PCF, FetchFault, InstrD, FetchCnt, NOP);
      else passed++;
      model_reset();
      do_release();
      repeat (3) tick();
      PCSrcE = 1; PCTargetE = 32'h42;
      tick();
      total++; if (PCF !== 32'h8 || FetchFault !== 1'b1 || ValidD !== 1'b0)
         $display("[TB] FAIL misaligned: got pcf=%h f=%b v=%b want 8 1 0", PCF, FetchFault, ValidD);
      else passed++;
      clear_inputs();
      tick();
      total++; if (PCF !== 32'h8 || FetchFault !== 1'b1)
         $display("[TB] FAIL misaligned_hold: got pcf=%h f=%b want 8 1", PCF, FetchFault);
      else passed++;
      @(negedge clk);
      #1 rst_n = 0;
      #1;
      total++; if (PCF !== 32'h0 || FetchFault !== 1'b0 || ValidD !== 1'b0 || FetchCnt !== 16'h0)
         $display("[TB] FAIL async_reset_mid: got pcf=%h f=%b v=%b cnt=%0d want 0 0 0 0", PCF, FetchFault, ValidD, FetchCnt);
      else passed++;
   endtask

   initial begin
      passed = 0; total = 0;
      for (int i = 0; i < 30; i++) imem[i] = $urandom;
      imem[0] = 32'h0050_0113;
      imem[1] = 32'h00C0_0193;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_under_stall();
      test_flush_beats_stall();
      test_random();
      test_halt_at_end();
      test_misaligned_and_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
